// File: rtl/dpcm_rate_output_pkg.sv
// DPCM output-path constants shared by the rate timer and the output unit.
package dpcm_rate_output_pkg;

    localparam int DPCM_FR_W     = 9;
    localparam int DPCM_OUT_W    = 7;
    localparam int DPCM_UP_LIMIT = 125;
    localparam int DPCM_DN_LIMIT = 2;
    localparam int DPCM_STEP     = 2;
    localparam int DPCM_BITS     = 8;
    localparam int DPCM_BC_W     = $clog2(DPCM_BITS);

endpackage

// File: rtl/dpcm_rate_timer.sv
// DPCM rate timer: down counter reloaded from FR, one tick per period.
module dpcm_rate_timer
    import dpcm_rate_output_pkg::*;
#(
    parameter int FR_W = DPCM_FR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic [FR_W-1:0] fr,
    output logic            tick
);

    logic [FR_W-1:0] cnt_q;
    logic [FR_W-1:0] cnt_d;
    logic [FR_W-1:0] reload;

    always_comb begin
        // FR of 0 behaves as a period of one ce cycle
        reload = (fr == '0) ? '0 : fr - FR_W'(1);
        tick   = ce && rst_n && (cnt_q == '0);
        cnt_d  = cnt_q;
        if (ce) begin
            cnt_d = (cnt_q == '0) ? reload : cnt_q - FR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dpcm_rate_output.sv
// DPCM output unit: sample shift register, bit counter and clamped delta DAC,
// clocked by the rate timer.
module dpcm_rate_output
    import dpcm_rate_output_pkg::*;
#(
    parameter int FR_W  = DPCM_FR_W,
    parameter int OUT_W = DPCM_OUT_W
) (
    input  logic             ACLK,
    input  logic             n_RES,
    input  logic             ce,
    input  logic [FR_W-1:0]  FR,
    input  logic             buf_valid,
    input  logic [7:0]       buf_data,
    output logic             buf_ack,
    input  logic             dac_load,
    input  logic [OUT_W-1:0] dac_data,
    output logic             tick,
    output logic             silence,
    output logic [OUT_W-1:0] DOUT
);

    logic [OUT_W-1:0]     dout_q, dout_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [DPCM_BC_W-1:0] bitcnt_q, bitcnt_d;
    logic                 silence_q, silence_d;
    logic                 ack;

    dpcm_rate_timer #(
        .FR_W(FR_W)
    ) u_timer (
        .clk  (ACLK),
        .rst_n(n_RES),
        .ce   (ce),
        .fr   (FR),
        .tick (tick)
    );

    always_comb begin
        dout_d    = dout_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        silence_d = silence_q;
        ack       = 1'b0;
        if (tick) begin
            if (!silence_q) begin
                if (shreg_q[0]) begin
                    if (dout_q <= OUT_W'(DPCM_UP_LIMIT))
                        dout_d = dout_q + OUT_W'(DPCM_STEP);
                end else if (dout_q >= OUT_W'(DPCM_DN_LIMIT)) begin
                    dout_d = dout_q - OUT_W'(DPCM_STEP);
                end
            end
            shreg_d = shreg_q >> 1;
            if (bitcnt_q == '0) begin
                bitcnt_d = DPCM_BC_W'(DPCM_BITS - 1);
                if (buf_valid) begin
                    shreg_d   = buf_data;
                    silence_d = 1'b0;
                    ack       = 1'b1;
                end else begin
                    silence_d = 1'b1;
                end
            end else begin
                bitcnt_d = bitcnt_q - DPCM_BC_W'(1);
            end
        end
        // A direct DAC write overrides the delta step on the same edge
        if (dac_load) begin
            dout_d = dac_data;
        end
    end

    always_ff @(posedge ACLK or negedge n_RES) begin
        if (!n_RES) begin
            dout_q    <= '0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            silence_q <= 1'b1;
        end else begin
            dout_q    <= dout_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            silence_q <= silence_d;
        end
    end

    assign buf_ack = ack;
    assign silence = silence_q;
    assign DOUT    = dout_q;

endmodule

// File: tb/tb_dpcm_rate_output.sv
// Scoreboard bench for dpcm_rate_output: each expected tick is queued by the
// stimulus and matched by a negedge monitor.
module tb_dpcm_rate_output;

    logic       ACLK = 1'b0;
    logic       n_RES;
    logic       ce;
    logic [8:0] FR;
    logic       buf_valid;
    logic [7:0] buf_data;
    logic       buf_ack;
    logic       dac_load;
    logic [6:0] dac_data;
    logic       tick;
    logic       silence;
    logic [6:0] DOUT;

    typedef struct {
        int         cyc;
        logic       ack;
        logic       sil;
        logic [6:0] dout;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    bit   done   = 0;

    dpcm_rate_output dut (
        .ACLK     (ACLK),
        .n_RES    (n_RES),
        .ce       (ce),
        .FR       (FR),
        .buf_valid(buf_valid),
        .buf_data (buf_data),
        .buf_ack  (buf_ack),
        .dac_load (dac_load),
        .dac_data (dac_data),
        .tick     (tick),
        .silence  (silence),
        .DOUT     (DOUT)
    );

    always #5 ACLK = ~ACLK;

    task automatic push(input int c, input logic a, input logic s,
                        input logic [6:0] d);
        exp_t t;
        t.cyc  = c;
        t.ack  = a;
        t.sil  = s;
        t.dout = d;
        q.push_back(t);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    // Hold reset across one negedge with ce=1, then release with ce=0 at cycle 0
    task automatic do_reset();
        n_RES     = 1'b0;
        ce        = 1'b1;
        FR        = '0;
        buf_valid = 1'b0;
        buf_data  = '0;
        dac_load  = 1'b0;
        dac_data  = '0;
        @(posedge ACLK);
        #1;
        n_RES = 1'b1;
        ce    = 1'b0;
        cyc   = 0;
    endtask

    // Cycle 0: DAC preload; cycle 1: first tick offers a byte; ticks every cycle to 10
    task automatic run(input logic [6:0] dac, input logic v,
                       input logic [7:0] data, input int ld_cyc,
                       input logic [6:0] ld_val);
        do_reset();
        dac_load = 1'b1;
        dac_data = dac;
        step();
        dac_load  = 1'b0;
        ce        = 1'b1;
        FR        = 9'd1;
        buf_valid = v;
        buf_data  = data;
        step();
        buf_valid = 1'b0;
        repeat (9) begin
            step();
            dac_load = (cyc == ld_cyc);
            dac_data = ld_val;
        end
        ce       = 1'b0;
        dac_load = 1'b0;
        step();
    endtask

    always @(negedge ACLK) begin
        if (!n_RES) begin
            checks++;
            if (DOUT !== 7'd0 || silence !== 1'b1 || tick !== 1'b0 ||
                buf_ack !== 1'b0)
                $display("FAIL reset: dout=%0d sil=%b tick=%b ack=%b, want 0 1 0 0",
                         DOUT, silence, tick, buf_ack);
            else
                passes++;
        end else if (tick) begin
            checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_tick at cyc=%0d", cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || buf_ack !== e.ack ||
                    silence !== e.sil || DOUT !== e.dout)
                    $display("FAIL tick: got cyc=%0d ack=%b sil=%b dout=%0d, want cyc=%0d ack=%b sil=%b dout=%0d",
                             cyc, buf_ack, silence, DOUT,
                             e.cyc, e.ack, e.sil, e.dout);
                else
                    passes++;
            end
        end else if (buf_ack) begin
            checks++;
            $display("FAIL ack_without_tick at cyc=%0d: ack=%b, want 0",
                     cyc, buf_ack);
        end
        if (done) begin
            checks++;
            if (q.size() != 0)
                $display("FAIL missing_ticks: %0d left, want 0 (next cyc=%0d)",
                         q.size(), q[0].cyc);
            else
                passes++;
            $display("%0d/%0d checks passed", passes, checks);
            $finish;
        end
    end

    initial begin
        n_RES     = 1'b0;
        ce        = 1'b0;
        FR        = '0;
        buf_valid = 1'b0;
        buf_data  = '0;
        dac_load  = 1'b0;
        dac_data  = '0;
        @(posedge ACLK);
        #1;

        // T1: FR=4, then FR=2 mid-period takes effect after the tick at 12
        do_reset();
        ce = 1'b1;
        FR = 9'd4;
        push(0, 0, 1, 0);
        push(4, 0, 1, 0);
        push(8, 0, 1, 0);
        push(12, 0, 1, 0);
        push(14, 0, 1, 0);
        push(16, 0, 1, 0);
        while (cyc < 17) begin
            step();
            if (cyc == 9) FR = 9'd2;
        end

        // T2: FR=0 ticks every ce cycle; ce toggling gates the ticks
        FR = 9'd0;
        for (int c = 18; c <= 21; c++) push(c, 0, 1, 0);
        for (int c = 22; c <= 28; c += 2) push(c, 0, 1, 0);
        while (cyc < 30) begin
            step();
            if (cyc >= 22) ce = (cyc % 2 == 0);
        end
        ce = 1'b0;
        step();

        // T3: byte 0xFF from 64 ramps 66..80
        push(1, 1, 1, 64);
        for (int k = 2; k <= 9; k++) push(k, 0, 0, 7'(64 + 2 * (k - 2)));
        push(10, 0, 1, 80);
        run(7'd64, 1'b1, 8'hFF, -1, 7'd0);

        // T4: clamp at the top and bottom
        push(1, 1, 1, 124);
        push(2, 0, 0, 124);
        for (int k = 3; k <= 9; k++) push(k, 0, 0, 126);
        push(10, 0, 1, 126);
        run(7'd124, 1'b1, 8'hFF, -1, 7'd0);

        push(1, 1, 1, 3);
        push(2, 0, 0, 3);
        for (int k = 3; k <= 9; k++) push(k, 0, 0, 1);
        push(10, 0, 1, 1);
        run(7'd3, 1'b1, 8'h00, -1, 7'd0);

        // T5: no byte at cycle end keeps DOUT constant and silent
        push(1, 0, 1, 40);
        for (int k = 2; k <= 10; k++) push(k, 0, 1, 40);
        run(7'd40, 1'b0, 8'hFF, -1, 7'd0);

        // T5: dac_load on the tick at cycle 3 overrides DOUT, bit count keeps going
        push(1, 1, 1, 64);
        push(2, 0, 0, 64);
        push(3, 0, 0, 66);
        for (int k = 4; k <= 9; k++) push(k, 0, 0, 7'(10 + 2 * (k - 4)));
        push(10, 0, 1, 22);
        run(7'd64, 1'b1, 8'hFF, 3, 7'd10);

        // T6: asynchronous reset mid-byte, then restart as T1
        do_reset();
        dac_load = 1'b1;
        dac_data = 7'd50;
        step();
        dac_load  = 1'b0;
        ce        = 1'b1;
        FR        = 9'd1;
        buf_valid = 1'b1;
        buf_data  = 8'hFF;
        push(1, 1, 1, 50);
        push(2, 0, 0, 50);
        push(3, 0, 0, 52);
        step();
        buf_valid = 1'b0;
        step();
        step();
        do_reset();
        ce = 1'b1;
        FR = 9'd4;
        push(0, 0, 1, 0);
        push(4, 0, 1, 0);
        push(8, 0, 1, 0);
        while (cyc < 10) step();
        ce = 1'b0;
        step();

        done = 1;
        repeat (5) @(posedge ACLK);
        $display("FAIL monitor did not finish");
        $fatal(1);
    end

endmodule
